// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Destinations are stored at a fixed maximum width so the entry type stays unparameterised.
package pipe_ctrl_pkg;

  localparam int unsigned MAX_REG_AW  = 8;
  localparam int unsigned FWD_REGFILE = 0;

  // One in-flight instruction as seen by the shadow scoreboard
  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] dest;
    logic                  wb_en;
    logic                  mem_r_en;
  } sb_entry_t;

  // Select width: 0 = register file, k+1 = tracked stage k
  function automatic int unsigned sel_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller beside ID: shadow scoreboard, stall/bubble/flush and forwarding selects.
// Define PIPE_FORWARDING_EN to stall only on load-use and drive the forwarding selects.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 4,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [REG_AW-1:0]              id_src1,
  input  logic [REG_AW-1:0]              id_src2,
  input  logic                           id_two_src,
  input  logic [REG_AW-1:0]              id_dest,
  input  logic                           id_wb_en,
  input  logic                           id_mem_r_en,
  input  logic                           exe_br_taken,
  output logic                           freeze,
  output logic                           bubble,
  output logic                           flush_if,
  output logic [sel_width(STAGES)-1:0]   fwd_sel1,
  output logic [sel_width(STAGES)-1:0]   fwd_sel2,
  output logic [CNT_W-1:0]               stall_cnt,
  output logic [CNT_W-1:0]               flush_cnt
);

  localparam int unsigned SEL_W = sel_width(STAGES);

  sb_entry_t          sb_q [STAGES];
  logic [STAGES-1:0]  m1_c;
  logic [STAGES-1:0]  m2_c;
  logic               hazard_c;
  logic [SEL_W-1:0]   sel1_c;
  logic [SEL_W-1:0]   sel2_c;
  sb_entry_t          id_entry_c;

  // Per-stage source matches against the registered scoreboard
  always_comb begin
    m1_c = '0;
    m2_c = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      m1_c[k] = id_valid && sb_q[k].valid && sb_q[k].wb_en &&
                (sb_q[k].dest == MAX_REG_AW'(id_src1));
      m2_c[k] = id_valid && id_two_src && sb_q[k].valid && sb_q[k].wb_en &&
                (sb_q[k].dest == MAX_REG_AW'(id_src2));
    end
  end

`ifdef PIPE_FORWARDING_EN
  // Only a load in EXE cannot be forwarded; youngest matching producer wins
  always_comb begin
    hazard_c = (m1_c[0] || m2_c[0]) && sb_q[0].mem_r_en;
    sel1_c   = SEL_W'(FWD_REGFILE);
    sel2_c   = SEL_W'(FWD_REGFILE);
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      if (m1_c[k]) sel1_c = SEL_W'(k + 1);
      if (m2_c[k]) sel2_c = SEL_W'(k + 1);
    end
  end
`else
  always_comb begin
    hazard_c = (|m1_c) || (|m2_c);
    sel1_c   = SEL_W'(FWD_REGFILE);
    sel2_c   = SEL_W'(FWD_REGFILE);
  end
`endif

  // A taken branch kills the ID instruction, so it overrides any stall
  always_comb begin
    freeze   = 1'b0;
    bubble   = 1'b0;
    flush_if = 1'b0;
    fwd_sel1 = SEL_W'(FWD_REGFILE);
    fwd_sel2 = SEL_W'(FWD_REGFILE);
    if (!rst) begin
      freeze   = hazard_c && !exe_br_taken;
      bubble   = hazard_c || exe_br_taken;
      flush_if = exe_br_taken;
      fwd_sel1 = sel1_c;
      fwd_sel2 = sel2_c;
    end
  end

  always_comb begin
    id_entry_c          = '0;
    id_entry_c.valid    = id_valid && !bubble;
    id_entry_c.dest     = MAX_REG_AW'(id_dest);
    id_entry_c.wb_en    = id_wb_en;
    id_entry_c.mem_r_en = id_mem_r_en;
    if (!id_entry_c.valid) id_entry_c = '0;
  end

  // Downstream never stalls, so the scoreboard shifts every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) sb_q[k] <= '0;
    end else begin
      sb_q[0] <= id_entry_c;
      for (int unsigned k = 1; k < STAGES; k++) sb_q[k] <= sb_q[k-1];
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (freeze),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (exe_br_taken),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (STAGES=2, CNT_W=4) against an in-flight instruction list.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_AW = 4;
  localparam int unsigned STAGES = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int          CMAX   = 15;

  logic              clk;
  logic              rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_two_src;
  logic [REG_AW-1:0] id_dest;
  logic              id_wb_en;
  logic              id_mem_r_en;
  logic              exe_br_taken;
  logic              freeze;
  logic              bubble;
  logic              flush_if;
  logic [SEL_W-1:0]  fwd_sel1;
  logic [SEL_W-1:0]  fwd_sel2;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_mem_r_en  (id_mem_r_en),
    .exe_br_taken (exe_br_taken),
    .freeze       (freeze),
    .bubble       (bubble),
    .flush_if     (flush_if),
    .fwd_sel1     (fwd_sel1),
    .fwd_sel2     (fwd_sel2),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    int unsigned dest;
    bit          wb;
    bit          ld;
  } instr_t;

  instr_t   inflight[$];   // index 0 = issued most recently
  int       sc, fc;
  int       checks, errors;
  logic [6:0] exp_ctrl;
  logic [7:0] exp_cnt;
  logic [6:0] got_ctrl;
  logic [7:0] got_cnt;

  assign got_ctrl = {freeze, bubble, flush_if, fwd_sel1, fwd_sel2};
  assign got_cnt  = {stall_cnt, flush_cnt};

  // Expected outputs from the current ID inputs and the in-flight list
  function automatic void calc();
    bit hz, br, h1, h2;
    int s1, s2;
    hz = 0; s1 = 0; s2 = 0; br = exe_br_taken;
    if (id_valid) begin
      for (int k = 0; k < inflight.size(); k++) begin
        if (inflight[k].v && inflight[k].wb) begin
          h1 = (inflight[k].dest == int'(id_src1));
          h2 = id_two_src && (inflight[k].dest == int'(id_src2));
          if (h1 && s1 == 0) s1 = k + 1;
          if (h2 && s2 == 0) s2 = k + 1;
`ifdef PIPE_FORWARDING_EN
          if ((h1 || h2) && k == 0 && inflight[k].ld) hz = 1;
`else
          if (h1 || h2) hz = 1;
`endif
        end
      end
    end
`ifndef PIPE_FORWARDING_EN
    s1 = 0; s2 = 0;
`endif
    if (rst) exp_ctrl = '0;
    else     exp_ctrl = {hz && !br, hz || br, br, SEL_W'(s1), SEL_W'(s2)};
    exp_cnt = {CNT_W'(sc), CNT_W'(fc)};
  endfunction

  task automatic tick();
    instr_t e;
    @(posedge clk);
    calc();
    if (rst) begin
      inflight.delete();
      sc = 0;
      fc = 0;
    end else begin
      if (exp_ctrl[6] && sc < CMAX) sc++;
      if (exe_br_taken && fc < CMAX) fc++;
      e.v    = id_valid && !exp_ctrl[5];
      e.dest = int'(id_dest);
      e.wb   = id_wb_en;
      e.ld   = id_mem_r_en;
      inflight.push_front(e);
      if (inflight.size() > STAGES) void'(inflight.pop_back());
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input int s1, input int s2, input bit two,
                       input int d, input bit wb, input bit ld, input bit br);
    id_valid     = v;
    id_src1      = REG_AW'(s1);
    id_src2      = REG_AW'(s2);
    id_two_src   = two;
    id_dest      = REG_AW'(d);
    id_wb_en     = wb;
    id_mem_r_en  = ld;
    exe_br_taken = br;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    drive(1, 3, 0, 0, 5, 1, 0, 0);
    #1; calc();
    checks++;
    if ({got_ctrl, got_cnt} !== {exp_ctrl, exp_cnt}) begin
      errors++;
      $display("FAIL reset_model: got %b/%b expected %b/%b", got_ctrl, got_cnt, exp_ctrl, exp_cnt);
    end
    checks++;
    if ({got_ctrl, got_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL reset_zero: got %b/%b expected all zero", got_ctrl, got_cnt);
    end
    tick();
  endtask

  task automatic test_raw();
    bit first_sel_ok;
    pulse_reset();
    drive(1, 0, 0, 0, 2, 1, 0, 0);          // ADD R2
    #1; calc();
    checks++;
    if ({got_ctrl, got_cnt} !== {exp_ctrl, exp_cnt}) begin
      errors++;
      $display("FAIL raw_producer: got %b/%b expected %b/%b", got_ctrl, got_cnt, exp_ctrl, exp_cnt);
    end
    tick();
    drive(1, 2, 0, 0, 6, 1, 0, 0);          // reader of R2, held for 4 cycles
    first_sel_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; calc();
      if (i == 0) first_sel_ok = (fwd_sel1 === 2'd1);
      checks++;
      if ({got_ctrl, got_cnt} !== {exp_ctrl, exp_cnt}) begin
        errors++;
        $display("FAIL raw_cycle%0d: got %b/%b expected %b/%b", i, got_ctrl, got_cnt, exp_ctrl, exp_cnt);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
`ifdef PIPE_FORWARDING_EN
    if (stall_cnt !== 4'd0 || !first_sel_ok) begin
      errors++;
      $display("FAIL raw_total: stall_cnt %0d sel1_first_ok %0b expected 0 and 1", stall_cnt, first_sel_ok);
    end
`else
    if (stall_cnt !== 4'd2) begin
      errors++;
      $display("FAIL raw_total: stall_cnt %0d expected 2", stall_cnt);
    end
`endif
  endtask

  task automatic test_load_use();
    logic [SEL_W-1:0] rel_sel2;
    for (int two = 1; two >= 0; two--) begin
      pulse_reset();
      drive(1, 0, 0, 0, 4, 1, 1, 0);        // LDR R4
      tick();
      drive(1, 0, 4, bit'(two), 7, 1, 0, 0);
      rel_sel2 = '0;
      for (int i = 0; i < 4; i++) begin
        #1; calc();
        checks++;
        if ({got_ctrl, got_cnt} !== {exp_ctrl, exp_cnt}) begin
          errors++;
          $display("FAIL load_use_two%0d_c%0d: got %b/%b expected %b/%b", two, i, got_ctrl, got_cnt, exp_ctrl, exp_cnt);
        end
        if (!freeze) begin
          rel_sel2 = fwd_sel2;
          tick();
          break;
        end
        tick();
      end
      #1;
      checks++;
`ifdef PIPE_FORWARDING_EN
      if (two == 1 && (stall_cnt !== 4'd1 || rel_sel2 !== 2'd2)) begin
        errors++;
        $display("FAIL load_use_fwd: stall_cnt %0d sel2 %0d expected 1 and 2", stall_cnt, rel_sel2);
      end
`else
      if (two == 1 && stall_cnt !== 4'd2) begin
        errors++;
        $display("FAIL load_use_legacy: stall_cnt %0d expected 2", stall_cnt);
      end
`endif
      if (two == 0 && stall_cnt !== 4'd0) begin
        errors++;
        $display("FAIL load_use_one_src: stall_cnt %0d expected 0", stall_cnt);
      end
    end
  endtask

  task automatic test_branch();
    pulse_reset();
    drive(1, 0, 0, 0, 5, 1, 0, 0);          // ADD R5
    tick();
    drive(1, 5, 0, 0, 7, 1, 0, 1);          // hazard on R5 with a taken branch
    #1; calc();
    checks++;
    if ({got_ctrl, got_cnt} !== {exp_ctrl, exp_cnt}) begin
      errors++;
      $display("FAIL branch_model: got %b/%b expected %b/%b", got_ctrl, got_cnt, exp_ctrl, exp_cnt);
    end
    checks++;
    if ({freeze, bubble, flush_if} !== 3'b011) begin
      errors++;
      $display("FAIL branch_ctrl: freeze/bubble/flush %b expected 011", {freeze, bubble, flush_if});
    end
    tick();
    drive(1, 7, 0, 0, 8, 1, 0, 0);          // reads the killed instruction's dest
    #1; calc();
    checks++;
    if ({got_ctrl, got_cnt} !== {exp_ctrl, exp_cnt}) begin
      errors++;
      $display("FAIL branch_after: got %b/%b expected %b/%b", got_ctrl, got_cnt, exp_ctrl, exp_cnt);
    end
    checks++;
    if (flush_cnt !== 4'd1 || freeze !== 1'b0 || fwd_sel1 !== 2'd0) begin
      errors++;
      $display("FAIL branch_killed: flush_cnt %0d freeze %b sel1 %0d expected 1 0 0", flush_cnt, freeze, fwd_sel1);
    end
    tick();
  endtask

  task automatic test_random();
    bit held;
    held = 0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!held) begin
        drive($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0, 1'b0);
      end
      exe_br_taken = ($urandom_range(0, 7) == 0);
      #1; calc();
      checks++;
      if ({got_ctrl, got_cnt} !== {exp_ctrl, exp_cnt}) begin
        errors++;
        $display("FAIL random_c%0d: got %b/%b expected %b/%b", i, got_ctrl, got_cnt, exp_ctrl, exp_cnt);
      end
      held = exp_ctrl[6];
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    pulse_reset();
    for (int it = 0; it < 21; it++) begin
      drive(1, 0, 0, 0, 1, 1, 1, 0);        // LDR R1
      #1; calc();
      checks++;
      if ({got_ctrl, got_cnt} !== {exp_ctrl, exp_cnt}) begin
        errors++;
        $display("FAIL sat_prod%0d: got %b/%b expected %b/%b", it, got_ctrl, got_cnt, exp_ctrl, exp_cnt);
      end
      tick();
      drive(1, 1, 0, 0, 9, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
        #1; calc();
        checks++;
        if ({got_ctrl, got_cnt} !== {exp_ctrl, exp_cnt}) begin
          errors++;
          $display("FAIL sat_cons%0d_%0d: got %b/%b expected %b/%b", it, i, got_ctrl, got_cnt, exp_ctrl, exp_cnt);
        end
        if (!freeze) begin
          tick();
          break;
        end
        tick();
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold: stall_cnt %0d expected 15", stall_cnt);
    end
    drive(1, 0, 0, 0, 1, 1, 1, 0);
    tick();
    drive(1, 1, 0, 0, 9, 0, 0, 0);
    #1;
    checks++;
    if (freeze !== 1'b1) begin
      errors++;
      $display("FAIL sat_stalling: freeze %b expected 1", freeze);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (got_ctrl !== 7'd0) begin
      errors++;
      $display("FAIL rst_during: ctrl %b expected 0", got_ctrl);
    end
    tick();
    rst = 1'b0;
    #1; calc();
    checks++;
    if ({got_ctrl, got_cnt} !== 15'd0 || {exp_ctrl, exp_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL rst_after: got %b/%b expected all zero", got_ctrl, got_cnt);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sc = 0;
    fc = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_raw();
    test_load_use();
    test_branch();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
